// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one sram_wrapper between two requesters.
// Round-robin grant with an optional bounded burst lock. The winning command is
// registered onto the SRAM interface, and reads are tagged so that each
// response is routed back to the port that issued it.
// Optional per-port accept counters: define SRAM_ARB_STATS_EN.
module sram_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 7,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_val,
  input  logic [1:0]          req_lock,
  input  logic [1:0]          req_wr,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_val,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                mem_en,
  output logic                rd_req,
  output logic                wr_req,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   wr_data_in,
  input  logic                rd_data_val,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                err_orphan_rsp
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0]         gnt_cnt0,
  output logic [31:0]         gnt_cnt1
`endif
);

  // Last locked beat index; MAX_BURST = 1 gives 0, so a lock can never be taken.
  localparam logic [4:0] BURST_LIM = 5'(MAX_BURST - 1);

  logic              rr_ptr_q, rr_ptr_d;
  logic              lock_active_q, lock_active_d;
  logic              owner_q, owner_d;
  logic [4:0]        beat_cnt_q, beat_cnt_d;
  logic              tag1_valid_q, tag1_valid_d;
  logic              tag1_id_q, tag1_id_d;
  logic              tag2_valid_q, tag2_valid_d;
  logic              tag2_id_q, tag2_id_d;
  logic              mem_en_q, mem_en_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] wr_data_in_q, wr_data_in_d;
  logic              err_orphan_q, err_orphan_d;

  logic       lock_hold;
  logic [1:0] grant;
  logic       accept;
  logic       acc_id;
  logic [4:0] beat_eff;

  // Grant selection: a live lock pins the owner, otherwise round-robin from rr_ptr.
  always_comb begin
    lock_hold = lock_active_q & req_val[owner_q];
    grant     = 2'b00;
    if (lock_hold) begin
      grant[owner_q] = 1'b1;
    end else if (req_val[rr_ptr_q]) begin
      grant[rr_ptr_q] = 1'b1;
    end else if (req_val[~rr_ptr_q]) begin
      grant[~rr_ptr_q] = 1'b1;
    end
    req_ready = rst_n ? grant : 2'b00;
    accept    = |req_ready;
    acc_id    = req_ready[1];
    // A dropped lock restarts the beat count, even if the other port wins this cycle.
    beat_eff  = lock_hold ? beat_cnt_q : 5'd0;
  end

  // Arbitration state: round-robin pointer and burst lock bookkeeping.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    lock_active_d = lock_active_q;
    owner_d       = owner_q;
    beat_cnt_d    = beat_cnt_q;
    if (lock_active_q && !req_val[owner_q]) begin
      lock_active_d = 1'b0;
      beat_cnt_d    = 5'd0;
    end
    if (accept) begin
      rr_ptr_d = ~acc_id;
      if (req_lock[acc_id] && (beat_eff < BURST_LIM)) begin
        lock_active_d = 1'b1;
        owner_d       = acc_id;
        beat_cnt_d    = beat_eff + 5'd1;
      end else begin
        lock_active_d = 1'b0;
        beat_cnt_d    = 5'd0;
      end
    end
  end

  // SRAM command register: launch the accepted command, address/data hold when idle.
  always_comb begin
    mem_en_d     = accept;
    rd_req_d     = accept & ~req_wr[acc_id];
    wr_req_d     = accept & req_wr[acc_id];
    address_d    = address_q;
    wr_data_in_d = wr_data_in_q;
    if (accept) begin
      address_d    = acc_id ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
      wr_data_in_d = acc_id ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
    end
  end

  // Read tag pipeline: stage 2 lines up with rd_data_val from the SRAM.
  always_comb begin
    tag1_valid_d = accept & ~req_wr[acc_id];
    tag1_id_d    = acc_id;
    tag2_valid_d = tag1_valid_q;
    tag2_id_d    = tag1_id_q;
    err_orphan_d = err_orphan_q | (rd_data_val & ~tag2_valid_q);
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= 1'b0;
      lock_active_q <= 1'b0;
      owner_q       <= 1'b0;
      beat_cnt_q    <= 5'd0;
      tag1_valid_q  <= 1'b0;
      tag1_id_q     <= 1'b0;
      tag2_valid_q  <= 1'b0;
      tag2_id_q     <= 1'b0;
      mem_en_q      <= 1'b0;
      rd_req_q      <= 1'b0;
      wr_req_q      <= 1'b0;
      address_q     <= '0;
      wr_data_in_q  <= '0;
      err_orphan_q  <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      lock_active_q <= lock_active_d;
      owner_q       <= owner_d;
      beat_cnt_q    <= beat_cnt_d;
      tag1_valid_q  <= tag1_valid_d;
      tag1_id_q     <= tag1_id_d;
      tag2_valid_q  <= tag2_valid_d;
      tag2_id_q     <= tag2_id_d;
      mem_en_q      <= mem_en_d;
      rd_req_q      <= rd_req_d;
      wr_req_q      <= wr_req_d;
      address_q     <= address_d;
      wr_data_in_q  <= wr_data_in_d;
      err_orphan_q  <= err_orphan_d;
    end
  end

  assign mem_en         = mem_en_q;
  assign rd_req         = rd_req_q;
  assign wr_req         = wr_req_q;
  assign address        = address_q;
  assign wr_data_in     = wr_data_in_q;
  assign err_orphan_rsp = err_orphan_q;
  assign rsp_data       = rd_data;
  assign rsp_val        = (rst_n && rd_data_val && tag2_valid_q) ?
                          (tag2_id_q ? 2'b10 : 2'b01) : 2'b00;

`ifdef SRAM_ARB_STATS_EN
  logic [31:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [31:0] gnt_cnt1_q, gnt_cnt1_d;

  // Saturating per-port accept counters.
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (accept && !acc_id && (gnt_cnt0_q != 32'hFFFF_FFFF)) gnt_cnt0_d = gnt_cnt0_q + 32'd1;
    if (accept && acc_id && (gnt_cnt1_q != 32'hFFFF_FFFF)) gnt_cnt1_d = gnt_cnt1_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_q <= 32'd0;
      gnt_cnt1_q <= 32'd0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios plus a randomized run checked against
// a transaction-level reference model of the two-port SRAM arbiter.
module tb_sram_port_arbiter;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 7;
  localparam int MAX_BURST = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          req_val = '0;
  logic [1:0]          req_lock = '0;
  logic [1:0]          req_wr = '0;
  logic [2*ADDR_W-1:0] req_addr = '0;
  logic [2*DATA_W-1:0] req_wdata = '0;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_val;
  logic [DATA_W-1:0]   rsp_data;
  logic                mem_en;
  logic                rd_req;
  logic                wr_req;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   wr_data_in;
  logic                rd_data_val;
  logic [DATA_W-1:0]   rd_data = '0;
  logic                err_orphan_rsp;
`ifdef SRAM_ARB_STATS_EN
  logic [31:0]         gnt_cnt0;
  logic [31:0]         gnt_cnt1;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  // SRAM model: one-cycle read latency, write on wr_req.
  logic [DATA_W-1:0] sram    [0:127];
  logic [DATA_W-1:0] ref_mem [0:127];
  logic              sram_val = 1'b0;
  logic              force_orphan = 1'b0;

  assign rd_data_val = sram_val | force_orphan;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    sram_val <= rd_req;
    rd_data  <= sram[address];
    if (wr_req) sram[address] <= wr_data_in;
  end

  sram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_lock(req_lock), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_val(rsp_val), .rsp_data(rsp_data),
    .mem_en(mem_en), .rd_req(rd_req), .wr_req(wr_req),
    .address(address), .wr_data_in(wr_data_in),
    .rd_data_val(rd_data_val), .rd_data(rd_data),
    .err_orphan_rsp(err_orphan_rsp)
`ifdef SRAM_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  // Drive one cycle of requests at the falling edge, settle before checks.
  task automatic applyStimulus(input logic [1:0] val, input logic [1:0] lock,
                               input logic [1:0] wr, input logic [2*ADDR_W-1:0] addr,
                               input logic [2*DATA_W-1:0] wdata);
    @(negedge clk);
    req_val   = val;
    req_lock  = lock;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    req_val = '0; req_lock = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    int                due;
    int                port;
    logic [DATA_W-1:0] data;
  } rsp_t;

  // Reference model state.
  rsp_t              rq[$];
  int                m_next, m_owner, m_run, g;
  bit                m_locked;
  bit   [1:0]        pend, pwr, plock;
  logic [ADDR_W-1:0] paddr [2];
  logic [DATA_W-1:0] pdata [2];
  logic [1:0]        exp_ready, exp_rv;
  logic [DATA_W-1:0] exp_rd, exp_wd;
  logic [ADDR_W-1:0] exp_addr;
  logic              exp_en, exp_wr, exp_rdq;
  int                cnt0, cnt1;
  logic [1:0]        seq [6];

  initial begin
    for (int a = 0; a < 128; a++) sram[a] = 32'h0;
    sram[5] = 32'hA5A5_0005;
    sram[1] = 32'h1111_0001;
    sram[2] = 32'h2222_0002;

    // ---- reset state ----
    req_val = 2'b11;
    #1;
    checkOutput("reset_ready", req_ready, 2'b00);
    checkOutput("reset_rsp_val", rsp_val, 2'b00);
    repeat (2) @(negedge clk);
    checkOutput("reset_mem_en", mem_en, 1'b0);
    checkOutput("reset_rd_req", rd_req, 1'b0);
    checkOutput("reset_wr_req", wr_req, 1'b0);
    checkOutput("reset_address", address, 7'd0);
    checkOutput("reset_wdata", wr_data_in, 32'd0);
    checkOutput("reset_err", err_orphan_rsp, 1'b0);
    doReset();

    // ---- single read ----
    applyStimulus(2'b01, 2'b00, 2'b00, {7'd0, 7'd5}, {32'h0, 32'h0});
    checkOutput("single_ready", req_ready, 2'b01);
    applyStimulus(2'b00, 2'b00, 2'b00, '0, '0);
    checkOutput("single_mem_en", mem_en, 1'b1);
    checkOutput("single_rd_req", rd_req, 1'b1);
    checkOutput("single_wr_req", wr_req, 1'b0);
    checkOutput("single_address", address, 7'd5);
    checkOutput("single_rsp_early", rsp_val, 2'b00);
    applyStimulus(2'b00, 2'b00, 2'b00, '0, '0);
    checkOutput("single_rsp_val", rsp_val, 2'b01);
    checkOutput("single_rsp_data", rsp_data, 32'hA5A5_0005);
    checkOutput("single_err", err_orphan_rsp, 1'b0);
    applyStimulus(2'b00, 2'b00, 2'b00, '0, '0);
    checkOutput("single_rsp_after", rsp_val, 2'b00);
    checkOutput("single_idle_en", mem_en, 1'b0);
    checkOutput("single_addr_hold", address, 7'd5);

    // ---- contention, no lock (writes, so no responses) ----
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b11, 2'b00, 2'b11, {7'd20, 7'd10}, {32'hBBBB_0001, 32'hAAAA_0000});
      checkOutput($sformatf("contend_ready_%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // ---- burst lock held by port 1 ----
    doReset();
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b10; seq[3] = 2'b10; seq[4] = 2'b10; seq[5] = 2'b01;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b11, 2'b10, 2'b11, {7'd21, 7'd11}, {32'h1, 32'h0});
      checkOutput($sformatf("burst_ready_%0d", i), req_ready, seq[i]);
    end

    // ---- owner drops mid-burst ----
    doReset();
    applyStimulus(2'b11, 2'b10, 2'b11, {7'd22, 7'd12}, '0);
    checkOutput("drop_ready_0", req_ready, 2'b01);
    applyStimulus(2'b11, 2'b10, 2'b11, {7'd22, 7'd12}, '0);
    checkOutput("drop_ready_1", req_ready, 2'b10);
    applyStimulus(2'b11, 2'b10, 2'b11, {7'd22, 7'd12}, '0);
    checkOutput("drop_ready_2", req_ready, 2'b10);
    applyStimulus(2'b01, 2'b10, 2'b11, {7'd22, 7'd12}, '0);
    checkOutput("drop_ready_3", req_ready, 2'b01);
    applyStimulus(2'b11, 2'b00, 2'b11, {7'd22, 7'd12}, '0);
    checkOutput("drop_ready_4", req_ready, 2'b10);

    // ---- interleaved reads ----
    doReset();
    applyStimulus(2'b11, 2'b00, 2'b00, {7'd2, 7'd1}, '0);
    checkOutput("ilv_ready_0", req_ready, 2'b01);
    applyStimulus(2'b10, 2'b00, 2'b00, {7'd2, 7'd1}, '0);
    checkOutput("ilv_ready_1", req_ready, 2'b10);
    applyStimulus(2'b00, 2'b00, 2'b00, '0, '0);
    checkOutput("ilv_rsp_val_0", rsp_val, 2'b01);
    checkOutput("ilv_rsp_data_0", rsp_data, 32'h1111_0001);
    applyStimulus(2'b00, 2'b00, 2'b00, '0, '0);
    checkOutput("ilv_rsp_val_1", rsp_val, 2'b10);
    checkOutput("ilv_rsp_data_1", rsp_data, 32'h2222_0002);

    // ---- orphan response ----
    applyStimulus(2'b00, 2'b00, 2'b00, '0, '0);
    force_orphan = 1'b1;
    #1;
    checkOutput("orphan_no_rsp", rsp_val, 2'b00);
    checkOutput("orphan_err_pre", err_orphan_rsp, 1'b0);
    @(negedge clk);
    force_orphan = 1'b0;
    #1;
    checkOutput("orphan_err_set", err_orphan_rsp, 1'b1);
    applyStimulus(2'b00, 2'b00, 2'b00, '0, '0);
    checkOutput("orphan_err_sticky", err_orphan_rsp, 1'b1);

    // ---- reset with a read in flight ----
    applyStimulus(2'b01, 2'b00, 2'b00, {7'd0, 7'd5}, '0);
    checkOutput("rst_rd_ready", req_ready, 2'b01);
    @(negedge clk);
    rst_n   = 1'b0;
    req_val = 2'b11;
    #1;
    checkOutput("rst_ready_gated", req_ready, 2'b00);
    checkOutput("rst_rsp_gated", rsp_val, 2'b00);
    checkOutput("rst_err_clear", err_orphan_rsp, 1'b0);
    @(negedge clk);
    req_val = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 2'b00, 2'b00, '0, '0);
      checkOutput($sformatf("rst_no_rsp_%0d", i), rsp_val, 2'b00);
      checkOutput($sformatf("rst_err_%0d", i), err_orphan_rsp, 1'b0);
    end
    force_orphan = 1'b1;
    @(negedge clk);
    force_orphan = 1'b0;
    #1;
    checkOutput("late_orphan_err", err_orphan_rsp, 1'b1);

    // ---- randomized traffic against the reference model ----
    doReset();
    for (int a = 0; a < 128; a++) begin
      sram[a]    = $urandom;
      ref_mem[a] = sram[a];
    end
    m_next = 0; m_owner = 0; m_run = 0; m_locked = 1'b0;
    pend = '0; pwr = '0; plock = '0;
    exp_en = 1'b0; exp_wr = 1'b0; exp_rdq = 1'b0; exp_addr = '0; exp_wd = '0;
    cnt0 = 0; cnt1 = 0;
    for (int p = 0; p < 2; p++) begin paddr[p] = '0; pdata[p] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 99) < 70)) begin
          pend[p]  = 1'b1;
          pwr[p]   = 1'($urandom_range(0, 1));
          paddr[p] = 7'($urandom_range(0, 127));
          pdata[p] = $urandom;
          plock[p] = ($urandom_range(0, 99) < 60);
        end
      end
      applyStimulus(pend, plock, pwr, {paddr[1], paddr[0]}, {pdata[1], pdata[0]});

      // A lock survives only while its owner keeps requesting.
      if (m_locked && !pend[m_owner]) begin m_locked = 1'b0; m_run = 0; end
      if (m_locked) g = m_owner;
      else if (pend[m_next]) g = m_next;
      else if (pend[1 - m_next]) g = 1 - m_next;
      else g = -1;
      exp_ready = (g < 0) ? 2'b00 : 2'(1 << g);
      checkOutput("rand_ready", req_ready, exp_ready);

      checkOutput("rand_mem_en", mem_en, exp_en);
      checkOutput("rand_rd_req", rd_req, exp_rdq);
      checkOutput("rand_wr_req", wr_req, exp_wr);
      checkOutput("rand_address", address, exp_addr);
      checkOutput("rand_wdata", wr_data_in, exp_wd);

      exp_rv = 2'b00;
      exp_rd = '0;
      if (rq.size() > 0 && rq[0].due == c) begin
        exp_rv = 2'(1 << rq[0].port);
        exp_rd = rq[0].data;
        void'(rq.pop_front());
      end
      checkOutput("rand_rsp_val", rsp_val, exp_rv);
      if (exp_rv != 2'b00) checkOutput("rand_rsp_data", rsp_data, exp_rd);
      checkOutput("rand_err", err_orphan_rsp, 1'b0);

      if (g >= 0) begin
        exp_en   = 1'b1;
        exp_wr   = pwr[g];
        exp_rdq  = !pwr[g];
        exp_addr = paddr[g];
        exp_wd   = pdata[g];
        if (pwr[g]) ref_mem[paddr[g]] = pdata[g];
        else rq.push_back('{c + 2, g, ref_mem[paddr[g]]});
        if (g == 0) cnt0++; else cnt1++;
        m_next = 1 - g;
        if (plock[g] && (m_run + 1 < MAX_BURST)) begin
          m_locked = 1'b1; m_owner = g; m_run = m_run + 1;
        end else begin
          m_locked = 1'b0; m_run = 0;
        end
        pend[g] = 1'b0;
      end else begin
        exp_en = 1'b0; exp_wr = 1'b0; exp_rdq = 1'b0;
      end
    end
    applyStimulus(2'b00, 2'b00, 2'b00, '0, '0);
    applyStimulus(2'b00, 2'b00, 2'b00, '0, '0);
    checkOutput("rand_drain", rq.size(), 0);
    $display("[TB] random run accepts port0=%0d port1=%0d", cnt0, cnt1);
`ifdef SRAM_ARB_STATS_EN
    checkOutput("stats_cnt0", gnt_cnt0, cnt0);
    checkOutput("stats_cnt1", gnt_cnt1, cnt1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
